uart_boot_loader: RTL

- Upstream stage of the single-cycle CPU.
- Receives a program image over a UART RX pin, assembles 32-bit instruction words, and writes them into the instruction memory write port.
- Holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.
- Contains its own oversampling UART receiver and a framing and packet FSM.

---
 rtl/uart_boot_loader_if.sv | 11 +
 rtl/uart_boot_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - instruction memory write port between boot loader and imem
interface uart_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_data;

    modport master (output imem_wren, output imem_address, output imem_data);
    modport slave  (input  imem_wren, input  imem_address, input  imem_data);
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART image receiver that fills imem and holds the CPU until the checksum passes
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_rx,
    uart_boot_loader_if.master        imem,
    output logic                      cpu_hold,
    output logic                      boot_done,
    output logic                      boot_error
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_COUNT, P_DATA, P_CHECK, P_DONE} p_state_t;

    logic             rx_meta, rx_sync;
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             rx_tick, half_tick, rx_valid, rx_ferr;

    p_state_t          p_state, p_next;
    logic [ADDR_W-1:0] addr_cnt, n_reg, last_addr;
    logic [1:0]        byte_lane;
    logic [31:0]       word_reg;
    logic [7:0]        csum;
    logic              hdr_seen, wr_word, set_done, set_err, last_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_tick   = (rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick = (rx_cnt == CNT_W'(HALF - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        if (rx_state == RX_STOP && rx_tick) begin
            rx_valid = rx_sync;
            rx_ferr  = !rx_sync;
        end
    end

    // The bit counter restarts on every state change so data samples land mid-bit after the half-bit start wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt  <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_state != rx_next || (rx_state == RX_DATA && rx_tick))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_state == RX_START)
                bit_idx <= '0;
            else if (rx_state == RX_DATA && rx_tick) begin
                bit_idx <= bit_idx + 3'd1;
                rx_byte <= {rx_sync, rx_byte[7:1]};
            end
        end
    end

    // N of zero wraps last_addr to all ones, giving a full 2^ADDR_W image.
    assign last_addr = n_reg - ADDR_W'(1);
    assign last_byte = (byte_lane == 2'd3) && (addr_cnt == last_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) p_state <= P_IDLE;
        else        p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        case (p_state)
            P_IDLE:  if (rx_valid && rx_byte == HDR_BYTE) p_next = P_COUNT;
            P_COUNT: if (rx_ferr) p_next = P_IDLE;
                     else if (rx_valid) p_next = P_DATA;
            P_DATA:  if (rx_ferr) p_next = P_IDLE;
                     else if (rx_valid && last_byte) p_next = P_CHECK;
            P_CHECK: if (rx_ferr) p_next = P_IDLE;
                     else if (rx_valid) p_next = (rx_byte == csum) ? P_DONE : P_IDLE;
            P_DONE:  p_next = P_DONE;
            default: p_next = P_IDLE;
        endcase
    end

    always_comb begin
        hdr_seen = (p_state == P_IDLE) && rx_valid && (rx_byte == HDR_BYTE);
        wr_word  = (p_state == P_DATA) && rx_valid && (byte_lane == 2'd3);
        set_done = (p_state == P_CHECK) && rx_valid && (rx_byte == csum);
        set_err  = ((p_state == P_CHECK) && rx_valid && (rx_byte != csum))
                 || (rx_ferr && (p_state == P_COUNT || p_state == P_DATA || p_state == P_CHECK));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt          <= '0;
            n_reg             <= '0;
            byte_lane         <= '0;
            word_reg          <= '0;
            csum              <= '0;
            imem.imem_wren    <= 1'b0;
            imem.imem_address <= '0;
            imem.imem_data    <= '0;
            boot_done         <= 1'b0;
            boot_error        <= 1'b0;
            cpu_hold          <= 1'b1;
        end else begin
            imem.imem_wren <= wr_word;
            if (wr_word) begin
                imem.imem_address <= addr_cnt;
                imem.imem_data    <= {rx_byte, word_reg[23:0]};
            end
            if (imem.imem_wren && addr_cnt != last_addr)
                addr_cnt <= addr_cnt + ADDR_W'(1);
            if (p_state == P_COUNT && rx_valid)
                n_reg <= ADDR_W'(rx_byte);
            if (p_state == P_DATA && rx_valid) begin
                word_reg[8*byte_lane +: 8] <= rx_byte;
                csum                       <= csum ^ rx_byte;
                byte_lane                  <= byte_lane + 2'd1;
            end
            if (hdr_seen) begin
                addr_cnt   <= '0;
                csum       <= '0;
                byte_lane  <= '0;
                boot_error <= 1'b0;
            end
            if (set_err)  boot_error <= 1'b1;
            if (set_done) boot_done  <= 1'b1;
            if (boot_done) cpu_hold  <= 1'b0;
        end
    end
endmodule
